cache_fill_ctrl: RTL

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

---
 rtl/cache_fill_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: fills one cache block after a miss.
// It issues WORDS_PER_BLOCK back-to-back word reads, then writes each returned
// word into the data array as it arrives. When the final word arrives it pulses
// write_tag_array and returns to idle.
// Optional build macro CACHE_FILL_CRITICAL_WORD_EN: fetch the missing word first
// and wrap around the block. The default build fills sequentially from the block base.
module cache_fill_ctrl #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [DATA_W-1:0]                  memory_data,
  output logic                               fsm_busy,
  output logic                               memory_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_index,
  output logic [DATA_W-1:0]                  cache_data,
  output logic                               write_tag_array
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  // Words are 2 bytes, so the block offset is one bit wider than the word index.
  localparam int OFF   = IDX_W + 1;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t                  state;
  logic [ADDR_W-OFF-1:0]   base_hi;
  logic [IDX_W-1:0]        start;
  logic [IDX_W-1:0]        issue_cnt;
  logic [IDX_W-1:0]        recv_cnt;
  logic [IDX_W-1:0]        miss_start;
  logic [IDX_W-1:0]        next_issue_idx;
  logic                    last_word;
  logic                    unused_addr_bits;

`ifdef CACHE_FILL_CRITICAL_WORD_EN
  // Start the fill at the word that actually missed.
  assign miss_start = miss_address[OFF-1:1];
`else
  // Always start the fill at the block base.
  assign miss_start = '0;
`endif

  // The byte-select bit never affects a word-addressed fill.
  assign unused_addr_bits = ^miss_address[OFF-1:0];

  // Word slot of the read after the current one. It wraps inside the block,
  // so the address never carries into the tag bits.
  assign next_issue_idx = start + issue_cnt + IDX_W'(1);

  assign last_word = (recv_cnt == IDX_W'(WORDS_PER_BLOCK - 1));

  // Fill sequencer: latch the block on a miss, stream the reads, and count returned words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      base_hi        <= '0;
      start          <= '0;
      issue_cnt      <= '0;
      recv_cnt       <= '0;
      memory_read_en <= 1'b0;
      memory_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state          <= FILL;
            base_hi        <= miss_address[ADDR_W-1:OFF];
            start          <= miss_start;
            issue_cnt      <= '0;
            recv_cnt       <= '0;
            memory_read_en <= 1'b1;
            memory_address <= {miss_address[ADDR_W-1:OFF], miss_start, 1'b0};
          end
        end
        FILL: begin
          if (memory_read_en) begin
            issue_cnt      <= issue_cnt + IDX_W'(1);
            memory_address <= {base_hi, next_issue_idx, 1'b0};
            if (issue_cnt == IDX_W'(WORDS_PER_BLOCK - 1)) begin
              memory_read_en <= 1'b0;
            end
          end
          if (memory_data_valid) begin
            recv_cnt <= recv_cnt + IDX_W'(1);
            if (last_word) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Returned words are written in the same cycle they arrive. Data outside a fill is ignored.
  always_comb begin
    fsm_busy         = (state == FILL);
    write_data_array = (state == FILL) && memory_data_valid;
    cache_word_index = start + recv_cnt;
    cache_data       = memory_data;
    write_tag_array  = (state == FILL) && memory_data_valid && last_word;
  end

endmodule
